lsu_rmw: RTL
============

Name: lsu_rmw

Overview:
- Parametrised load/store unit that replaces the fixed memory-data-register path between the ALU output register, register B and the 64-bit data memory.
- Adds byte, halfword, word and doubleword accesses, sign/zero extension, and misalignment detection.
- Implements partial stores as read-modify-write, because the data memory has no byte enables.
- Driven by the control unit through a START/DONE handshake; supports configurable data width and memory read latency.

Parameters:
XLEN, 64, datapath and memory word width in bits; legal values 32 or 64.
ADDR_W, 64, byte-address width.
MEM_LAT, 1, cycles from a stable MEM_ADDR until MEM_DOUT is valid; must be >= 1.

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  asynchronous, active-high reset.
START  in  1  request strobe; sampled only in IDLE.
WE  in  1  1 = store, 0 = load.
SIZE  in  2  00 byte, 01 half, 10 word, 11 double.
UNSIGNED  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
ADDR  in  ADDR_W  byte address (ALU output register).
WDATA  in  XLEN  store data (register B); low 8*bytes bits are used.
BUSY  out  1  high in every state except IDLE.
DONE  out  1  one-cycle completion pulse.
ERR  out  1  one-cycle misalignment/illegal-size pulse; coincides with DONE.
RDATA  out  XLEN  extended load result; holds its value until the next successful load.
MEM_ADDR  out  ADDR_W  word-aligned address: ADDR with its low log2(XLEN/8) bits cleared.
MEM_WR  out  1  memory write enable; memory writes on the CLK edge while high.
MEM_DIN  out  XLEN  memory write data.
MEM_DOUT  in  XLEN  memory read data.

Behaviour:
- Reset values: state IDLE; BUSY, DONE, ERR, MEM_WR = 0; RDATA, MEM_ADDR, MEM_DIN = 0.
- Reset is asynchronous and aborts any access in progress. MEM_WR is decoded from state only, so it drops immediately on RESET and no write is issued.
- On START in IDLE, capture ADDR, SIZE, WE, UNSIGNED and WDATA. Inputs are not used after capture.
- START while BUSY is ignored and has no effect.
- Alignment rules (off = byte offset of ADDR within the XLEN word):
  - byte: always legal.
  - half: requires off[0] = 0.
  - word: requires off[1:0] = 0.
  - double: requires off[2:0] = 0 and XLEN = 64; SIZE = 11 with XLEN = 32 is illegal.
- States:
  - IDLE: START with an illegal access -> ERRS. Full-width store (SIZE matches XLEN) -> WRITE. Any other access -> READ.
  - READ: MEM_ADDR held, MEM_WR = 0. A counter runs MEM_LAT cycles; MEM_DOUT is sampled on the last one.
    - Load: RDATA <= extend(MEM_DOUT[8*off +: 8*bytes]) -> DONES.
    - Partial store: latch merged word (MEM_DOUT with lanes [8*off +: 8*bytes] replaced by WDATA low bytes) -> WRITE.
  - WRITE: MEM_WR = 1 for exactly one cycle; MEM_DIN = merged word, or WDATA for full width -> DONES.
  - DONES: DONE = 1 -> IDLE.
  - ERRS: DONE = 1, ERR = 1; no memory access, RDATA unchanged -> IDLE.
- Data ordering is little-endian: byte lane 0 is bits [7:0].
- Latency, in cycles from the START sampling edge to the DONE-high cycle:
  - load: MEM_LAT+1
  - partial store: MEM_LAT+2
  - full store: 2
  - error: 1
- A new START is accepted in the cycle after DONE; there is no back-to-back acceptance in the DONE cycle.
- Stores never modify RDATA.
- MEM_ADDR stays stable from IDLE exit until return to IDLE.

Test Plan:
All scenarios use XLEN = 64 and MEM_LAT = 1 unless stated; memory word 0x100 = 0xF0E0D0C0B0A09080.

1. Loads:
   - LB 0x100 signed -> RDATA 0xFFFFFFFFFFFFFF80.
   - LBU 0x100 -> 0x80.
   - LH 0x102 -> 0xFFFFFFFFFFFFB0A0.
   - LWU 0x104 -> 0x00000000F0E0D0C0.
   - Each: DONE 2 cycles after START; MEM_ADDR = 0x100; MEM_WR never high.
2. SB 0x105, WDATA 0x12AB -> word 0xF0E0ABC0B0A09080; MEM_WR high exactly once, in cycle 2; DONE in cycle 3; RDATA unchanged.
3. SD 0x108, WDATA 0x0123456789ABCDEF -> no READ; MEM_WR in cycle 1 with MEM_DIN = WDATA; DONE in cycle 2.
4. Misaligned accesses:
   - LW 0x102 -> ERR = DONE = 1 in cycle 1, MEM_WR = 0, RDATA holds its prior value.
   - SD 0x104 -> same response.
5. Handshake and reset:
   - START pulsed while BUSY -> ignored; exactly one DONE results.
   - RESET asserted in the READ cycle of SH 0x100 -> BUSY = 0 and RDATA = 0 immediately; the memory word is unchanged (no MEM_WR).
6. MEM_LAT = 3 instance: LD 0x100 -> DONE 4 cycles after START, RDATA 0xF0E0D0C0B0A09080. XLEN = 32 instance: SIZE = 11 -> ERR.

Source files
------------

// File: rtl/lsu_rmw_if.sv
// Request/response and memory-side signals of the load/store unit.
//   slave  : the load/store unit itself
//   master : whoever drives requests and supplies memory read data
// Signals: START/WE/SIZE/UNSIGNED/ADDR/WDATA request, BUSY/DONE/ERR/RDATA
// response, MEM_ADDR/MEM_WR/MEM_DIN/MEM_DOUT memory port.
interface lsu_rmw_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
);
    logic              START;
    logic              WE;
    logic [1:0]        SIZE;
    logic              UNSIGNED;
    logic [ADDR_W-1:0] ADDR;
    logic [XLEN-1:0]   WDATA;
    logic              BUSY;
    logic              DONE;
    logic              ERR;
    logic [XLEN-1:0]   RDATA;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_WR;
    logic [XLEN-1:0]   MEM_DIN;
    logic [XLEN-1:0]   MEM_DOUT;

    modport slave (
        input  START, WE, SIZE, UNSIGNED, ADDR, WDATA, MEM_DOUT,
        output BUSY, DONE, ERR, RDATA, MEM_ADDR, MEM_WR, MEM_DIN
    );

    modport master (
        output START, WE, SIZE, UNSIGNED, ADDR, WDATA, MEM_DOUT,
        input  BUSY, DONE, ERR, RDATA, MEM_ADDR, MEM_WR, MEM_DIN
    );
endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit between the ALU output register, register B and a
// word-wide data memory without byte enables. Sub-word stores are done as
// read-modify-write; loads are sign/zero extended; misaligned or illegal
// sizes complete with ERR and no memory access.
// Ports:
//   CLK   - rising-edge clock
//   RESET - asynchronous active-high reset, aborts any access in progress
//   bus   - lsu_rmw_if slave: request handshake, result and memory port
module lsu_rmw #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int MEM_LAT = 1
) (
    input logic      CLK,
    input logic      RESET,
    lsu_rmw_if.slave bus
);
    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {IDLE, READ, WRITE, DONES, ERRS} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic [XLEN-1:0]   mem_din_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic [OFF_W-1:0]  off_in;
    logic              legal;
    logic              full;
    logic [OFF_W+2:0]  sh;
    logic [XLEN-1:0]   lane_mask;
    logic [XLEN-1:0]   dshift;
    logic [XLEN-1:0]   load_val;
    logic [XLEN-1:0]   merged;

    assign off_in = bus.ADDR[OFF_W-1:0];
    assign full   = (XLEN == 64) ? (bus.SIZE == 2'b11) : (bus.SIZE == 2'b10);

    always_comb begin
        unique case (bus.SIZE)
            2'b00: legal = 1'b1;
            2'b01: legal = ~off_in[0];
            2'b10: legal = (off_in[1:0] == 2'b00);
            2'b11: legal = (XLEN == 64) && (off_in == '0);
        endcase
    end

    // Byte offset turned into a bit shift; little-endian, lane 0 = [7:0].
    assign sh = {off_q, 3'b000};

    always_comb begin
        unique case (size_q)
            2'b00: lane_mask = XLEN'(8'hFF);
            2'b01: lane_mask = XLEN'(16'hFFFF);
            2'b10: lane_mask = XLEN'(32'hFFFF_FFFF);
            2'b11: lane_mask = '1;
        endcase
    end

    assign dshift = bus.MEM_DOUT >> sh;
    assign merged = (bus.MEM_DOUT & ~(lane_mask << sh)) | ((wdata_q & lane_mask) << sh);

    always_comb begin
        unique case (size_q)
            2'b00:
                if (uns_q) load_val = XLEN'(dshift[7:0]);
                else       load_val = XLEN'($signed(dshift[7:0]));
            2'b01:
                if (uns_q) load_val = XLEN'(dshift[15:0]);
                else       load_val = XLEN'($signed(dshift[15:0]));
            2'b10:
                if (uns_q) load_val = XLEN'(dshift[31:0]);
                else       load_val = XLEN'($signed(dshift[31:0]));
            2'b11: load_val = dshift;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mem_din_q  <= '0;
            mem_addr_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.START) begin
                        we_q       <= bus.WE;
                        uns_q      <= bus.UNSIGNED;
                        size_q     <= bus.SIZE;
                        off_q      <= off_in;
                        wdata_q    <= bus.WDATA;
                        mem_addr_q <= bus.ADDR & ~ADDR_W'(XLEN / 8 - 1);
                        cnt        <= '0;
                        if (!legal) begin
                            state <= ERRS;
                        end else if (bus.WE && full) begin
                            mem_din_q <= bus.WDATA;
                            state     <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (cnt == CNT_LAST) begin
                        if (we_q) begin
                            mem_din_q <= merged;
                            state     <= WRITE;
                        end else begin
                            rdata_q <= load_val;
                            state   <= DONES;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE:   state <= DONES;
                DONES:   state <= IDLE;
                ERRS:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Status and write strobe are pure state decodes so that an asynchronous
    // reset removes MEM_WR at once instead of at the next clock edge.
    assign bus.BUSY     = (state != IDLE);
    assign bus.DONE     = (state == DONES) || (state == ERRS);
    assign bus.ERR      = (state == ERRS);
    assign bus.MEM_WR   = (state == WRITE);
    assign bus.RDATA    = rdata_q;
    assign bus.MEM_ADDR = mem_addr_q;
    assign bus.MEM_DIN  = mem_din_q;
endmodule
